maxpool_stream: RTL and testbench

Parametrised streaming max-pool unit for the CNN datapath, the successor to the fixed 2x2, single-channel, 8-bit pooling buffer. It consumes a raster-order feature map of `CHANNELS` parallel signed lanes and emits one pooled pixel per `POOL`x`POOL` non-overlapping window (stride = `POOL`). It sits between a conv/activation stage and the next layer's line buffers, with valid/ready backpressure on both sides. It computes the max itself instead of exposing a raw window.

---
 rtl/maxpool_stream.sv | 186 ++++++++++++++++++
 tb/tb_maxpool_stream.sv | 341 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/maxpool_stream.sv
// maxpool_stream: streaming POOLxPOOL (stride POOL) signed max-pool over a
// raster-order feature map of CHANNELS parallel lanes, with valid/ready on
// both sides and a single registered output stage.
// Build option: define MAXPOOL_RELU_EN to clamp each pooled lane at zero
// (ReLU fused after pooling). Without it, raw signed maxima are emitted.

module maxpool_stream #(
  parameter int DATA_W   = 8,
  parameter int IMG_W    = 28,
  parameter int IMG_H    = 28,
  parameter int POOL     = 2,
  parameter int CHANNELS = 1
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [CHANNELS*DATA_W-1:0]   in_data,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [CHANNELS*DATA_W-1:0]   out_data,
  output logic                         out_last
);

  localparam int VW  = CHANNELS * DATA_W;
  localparam int GW  = IMG_W / POOL;
  localparam int CW  = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam int RW  = (IMG_H > 1) ? $clog2(IMG_H) : 1;
  localparam int PW  = (POOL > 1) ? $clog2(POOL) : 1;
  localparam int GXW = (GW > 1) ? $clog2(GW) : 1;
  localparam logic [DATA_W-1:0] LANE_MIN = {1'b1, {(DATA_W-1){1'b0}}};
  localparam logic [VW-1:0]     VEC_MIN  = {CHANNELS{LANE_MIN}};

  if ((IMG_W % POOL) != 0) begin : g_chk_w
    $error("maxpool_stream: IMG_W must be a multiple of POOL");
  end
  if ((IMG_H % POOL) != 0) begin : g_chk_h
    $error("maxpool_stream: IMG_H must be a multiple of POOL");
  end
  if ((POOL < 2) || (POOL > 4)) begin : g_chk_p
    $error("maxpool_stream: POOL must be in 2..4");
  end

  // Per-lane signed maximum of two packed pixels.
  function automatic logic [VW-1:0] vec_max(input logic [VW-1:0] a, input logic [VW-1:0] b);
    logic [VW-1:0] m;
    m = a;
    for (int c = 0; c < CHANNELS; c++) begin
      if ($signed(b[c*DATA_W +: DATA_W]) > $signed(a[c*DATA_W +: DATA_W])) begin
        m[c*DATA_W +: DATA_W] = b[c*DATA_W +: DATA_W];
      end else begin
        m[c*DATA_W +: DATA_W] = a[c*DATA_W +: DATA_W];
      end
    end
    return m;
  endfunction

  logic [CW-1:0]  col_r, col_nxt_s;
  logic [RW-1:0]  row_r, row_nxt_s;
  logic [PW-1:0]  cx_r, cx_nxt_s;
  logic [PW-1:0]  ry_r, ry_nxt_s;
  logic [GXW-1:0] gx_r, gx_nxt_s;
  logic [VW-1:0]  hmax_r;
  logic [VW-1:0]  acc_r [GW];
  logic [VW-1:0]  out_data_r;
  logic           out_valid_r;
  logic           out_last_r;

  logic           accept_s;
  logic           col_end_s;
  logic           win_done_s;
  logic           frame_end_s;
  logic [VW-1:0]  h_s;
  logic [VW-1:0]  acc_rd_s;
  logic [VW-1:0]  acc_new_s;
  logic [VW-1:0]  load_s;

  assign in_ready    = !out_valid_r || out_ready;
  assign accept_s    = in_valid && in_ready;
  assign col_end_s   = (cx_r == PW'(POOL-1));
  assign win_done_s  = accept_s && col_end_s && (ry_r == PW'(POOL-1));
  assign frame_end_s = (col_r == CW'(IMG_W-1)) && (row_r == RW'(IMG_H-1));

  // On the last row of a band acc_new_s is exactly the finished window max.
  assign h_s       = vec_max(hmax_r, in_data);
  assign acc_rd_s  = acc_r[gx_r];
  assign acc_new_s = (ry_r == {PW{1'b0}}) ? h_s : vec_max(acc_rd_s, h_s);

`ifdef MAXPOOL_RELU_EN
  // Clamp each lane at zero; a set sign bit means a negative maximum.
  function automatic logic [VW-1:0] vec_relu(input logic [VW-1:0] v);
    logic [VW-1:0] r;
    r = v;
    for (int c = 0; c < CHANNELS; c++) begin
      if (v[c*DATA_W + DATA_W - 1]) begin
        r[c*DATA_W +: DATA_W] = {DATA_W{1'b0}};
      end else begin
        r[c*DATA_W +: DATA_W] = v[c*DATA_W +: DATA_W];
      end
    end
    return r;
  endfunction
  assign load_s = vec_relu(acc_new_s);
`else
  assign load_s = acc_new_s;
`endif

  // Raster position advance on each accepted pixel, wrapping at frame end.
  always_comb begin
    col_nxt_s = col_r;
    row_nxt_s = row_r;
    cx_nxt_s  = cx_r;
    ry_nxt_s  = ry_r;
    gx_nxt_s  = gx_r;
    if (accept_s) begin
      if (col_r == CW'(IMG_W-1)) begin
        col_nxt_s = {CW{1'b0}};
        cx_nxt_s  = {PW{1'b0}};
        gx_nxt_s  = {GXW{1'b0}};
        if (row_r == RW'(IMG_H-1)) begin
          row_nxt_s = {RW{1'b0}};
          ry_nxt_s  = {PW{1'b0}};
        end else begin
          row_nxt_s = row_r + RW'(1);
          ry_nxt_s  = (ry_r == PW'(POOL-1)) ? {PW{1'b0}} : ry_r + PW'(1);
        end
      end else begin
        col_nxt_s = col_r + CW'(1);
        if (col_end_s) begin
          cx_nxt_s = {PW{1'b0}};
          gx_nxt_s = gx_r + GXW'(1);
        end else begin
          cx_nxt_s = cx_r + PW'(1);
        end
      end
    end else begin
      col_nxt_s = col_r;
    end
  end

  // Pixel-path state: counters, horizontal running max and partial-row buffer.
  always_ff @(posedge clk) begin
    if (rst) begin
      col_r  <= {CW{1'b0}};
      row_r  <= {RW{1'b0}};
      cx_r   <= {PW{1'b0}};
      ry_r   <= {PW{1'b0}};
      gx_r   <= {GXW{1'b0}};
      hmax_r <= VEC_MIN;
      for (int i = 0; i < GW; i++) begin
        acc_r[i] <= VEC_MIN;
      end
    end else if (accept_s) begin
      col_r  <= col_nxt_s;
      row_r  <= row_nxt_s;
      cx_r   <= cx_nxt_s;
      ry_r   <= ry_nxt_s;
      gx_r   <= gx_nxt_s;
      hmax_r <= (cx_r == {PW{1'b0}}) ? in_data : h_s;
      if (col_end_s) begin
        acc_r[gx_r] <= acc_new_s;
      end
    end
  end

  // Output stage: load on window completion (wins over drain), else drain.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_r <= 1'b0;
      out_last_r  <= 1'b0;
      out_data_r  <= VEC_MIN;
    end else if (win_done_s) begin
      out_valid_r <= 1'b1;
      out_last_r  <= frame_end_s;
      out_data_r  <= load_s;
    end else if (out_valid_r && out_ready) begin
      out_valid_r <= 1'b0;
      out_last_r  <= 1'b0;
    end
  end

  assign out_valid = out_valid_r;
  assign out_data  = out_data_r;
  assign out_last  = out_last_r;

endmodule

// File: tb/tb_maxpool_stream.sv
// tb_maxpool_stream: scoreboard bench for maxpool_stream. Instance A is a
// 4x4, POOL=2, single-channel unit; instance B is 6x6, POOL=3, two channels.
// Expected pooled pixels come from a window-based model of each frame.

module tb_maxpool_stream;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        a_in_valid, a_in_ready, a_out_valid, a_out_ready, a_out_last;
  logic [7:0]  a_in_data, a_out_data;
  logic        b_in_valid, b_in_ready, b_out_valid, b_out_ready, b_out_last;
  logic [15:0] b_in_data, b_out_data;

  maxpool_stream #(.DATA_W(8), .IMG_W(4), .IMG_H(4), .POOL(2), .CHANNELS(1)) u_dut_a (
    .clk(clk), .rst(rst),
    .in_valid(a_in_valid), .in_ready(a_in_ready), .in_data(a_in_data),
    .out_valid(a_out_valid), .out_ready(a_out_ready), .out_data(a_out_data),
    .out_last(a_out_last)
  );

  maxpool_stream #(.DATA_W(8), .IMG_W(6), .IMG_H(6), .POOL(3), .CHANNELS(2)) u_dut_b (
    .clk(clk), .rst(rst),
    .in_valid(b_in_valid), .in_ready(b_in_ready), .in_data(b_in_data),
    .out_valid(b_out_valid), .out_ready(b_out_ready), .out_data(b_out_data),
    .out_last(b_out_last)
  );

  typedef struct {
    logic [15:0] data;
    logic        last;
  } exp_t;

  exp_t       exp_a[$];
  exp_t       exp_b[$];
  logic [7:0] pix_a[$];
  logic [15:0] pix_b[$];
  int n_tests = 0;
  int n_fail  = 0;

  function automatic logic signed [7:0] relu8(input logic signed [7:0] v);
`ifdef MAXPOOL_RELU_EN
    return (v < 0) ? 8'sd0 : v;
`else
    return v;
`endif
  endfunction

  // Build one 4x4 frame for A and push its pixels plus expected pooled results.
  task automatic push_frame_a(input int mode);
    logic signed [7:0] img [16];
    logic signed [7:0] m;
    int idx;
    exp_t e;
    for (int i = 0; i < 16; i++) begin
      case (mode)
        0: img[i] = 8'(i);
        1: img[i] = 8'sh80;
        2: img[i] = 8'($urandom_range(0, 255));
        default: img[i] = 8'sd100;
      endcase
    end
    if (mode == 1) begin
      for (int wy = 0; wy < 2; wy++) begin
        for (int wx = 0; wx < 2; wx++) begin
          idx = (wy * 2 + wx) % 4;
          img[(wy * 2 + idx / 2) * 4 + wx * 2 + idx % 2] = -8'sd3;
        end
      end
    end
    for (int i = 0; i < 16; i++) pix_a.push_back(img[i]);
    for (int wy = 0; wy < 2; wy++) begin
      for (int wx = 0; wx < 2; wx++) begin
        m = img[wy * 8 + wx * 2];
        for (int dy = 0; dy < 2; dy++)
          for (int dx = 0; dx < 2; dx++)
            if (img[(wy * 2 + dy) * 4 + wx * 2 + dx] > m) m = img[(wy * 2 + dy) * 4 + wx * 2 + dx];
        e.data = {8'h00, relu8(m)};
        e.last = (wy == 1) && (wx == 1);
        exp_a.push_back(e);
      end
    end
  endtask

  // Build one 6x6 two-channel frame for B (mode 0: ch0=col, ch1=-row; else random).
  task automatic push_frame_b(input int mode);
    logic signed [7:0] img0 [36];
    logic signed [7:0] img1 [36];
    logic signed [7:0] m0, m1;
    exp_t e;
    for (int r = 0; r < 6; r++) begin
      for (int c = 0; c < 6; c++) begin
        if (mode == 0) begin
          img0[r * 6 + c] = 8'(c);
          img1[r * 6 + c] = 8'(-r);
        end else begin
          img0[r * 6 + c] = 8'($urandom_range(0, 255));
          img1[r * 6 + c] = 8'($urandom_range(0, 255));
        end
        pix_b.push_back({img1[r * 6 + c], img0[r * 6 + c]});
      end
    end
    for (int wy = 0; wy < 2; wy++) begin
      for (int wx = 0; wx < 2; wx++) begin
        m0 = 8'sh80;
        m1 = 8'sh80;
        for (int dy = 0; dy < 3; dy++) begin
          for (int dx = 0; dx < 3; dx++) begin
            if (img0[(wy * 3 + dy) * 6 + wx * 3 + dx] > m0) m0 = img0[(wy * 3 + dy) * 6 + wx * 3 + dx];
            if (img1[(wy * 3 + dy) * 6 + wx * 3 + dx] > m1) m1 = img1[(wy * 3 + dy) * 6 + wx * 3 + dx];
          end
        end
        e.data = {relu8(m1), relu8(m0)};
        e.last = (wy == 1) && (wx == 1);
        exp_b.push_back(e);
      end
    end
  endtask

  // Stream queued pixels into A, optional out_ready stall window, optional per-cycle latency check.
  task automatic run_a(input int stall_start, input int stall_len, input bit chk_lat);
    int cyc = 0;
    int pos = 0;
    bit prev_done = 1'b0;
    bit have_held = 1'b0;
    logic [7:0] held = 8'h00;
    exp_t e;
    while ((pix_a.size() > 0 || exp_a.size() > 0) && cyc < 300) begin
      @(negedge clk);
      a_out_ready = !((cyc >= stall_start) && (cyc < stall_start + stall_len));
      a_in_valid  = (pix_a.size() > 0);
      a_in_data   = a_in_valid ? pix_a[0] : 8'h00;
      #1;
      if (chk_lat) begin
        n_tests++;
        if (a_out_valid !== prev_done) begin
          n_fail++;
          $display("FAIL latency: cycle %0d out_valid got %b expected %b", cyc, a_out_valid, prev_done);
        end
      end
      prev_done = 1'b0;
      if (!a_out_ready && a_out_valid) begin
        if (!have_held) begin
          held = a_out_data;
          have_held = 1'b1;
        end
        n_tests++;
        if (a_in_ready !== 1'b0) begin
          n_fail++;
          $display("FAIL stall_in_ready: got %b expected 0", a_in_ready);
        end
        n_tests++;
        if (a_out_data !== held) begin
          n_fail++;
          $display("FAIL stall_hold: out_data got %h expected %h", a_out_data, held);
        end
      end
      if (a_in_valid && a_in_ready) begin
        prev_done = ((pos % 2) == 1) && (((pos / 4) % 2) == 1);
        pos = (pos + 1) % 16;
        void'(pix_a.pop_front());
      end
      if (a_out_valid && a_out_ready) begin
        n_tests++;
        if (exp_a.size() == 0) begin
          n_fail++;
          $display("FAIL a_extra: unexpected output %h", a_out_data);
        end else begin
          e = exp_a.pop_front();
          if (a_out_data !== e.data[7:0] || a_out_last !== e.last) begin
            n_fail++;
            $display("FAIL a_data: got %h last %b expected %h last %b",
                     a_out_data, a_out_last, e.data[7:0], e.last);
          end
        end
      end
      cyc++;
    end
    n_tests++;
    if (cyc >= 300) begin
      n_fail++;
      $display("FAIL a_timeout: %0d pixels and %0d results left", pix_a.size(), exp_a.size());
      pix_a.delete();
      exp_a.delete();
    end
    @(negedge clk);
    a_in_valid  = 1'b0;
    a_out_ready = 1'b1;
    #1;
    n_tests++;
    if (a_out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL a_idle: out_valid got %b expected 0", a_out_valid);
    end
  endtask

  // Stream queued pixels into B with out_ready held high.
  task automatic run_b();
    int cyc = 0;
    exp_t e;
    while ((pix_b.size() > 0 || exp_b.size() > 0) && cyc < 300) begin
      @(negedge clk);
      b_out_ready = 1'b1;
      b_in_valid  = (pix_b.size() > 0);
      b_in_data   = b_in_valid ? pix_b[0] : 16'h0000;
      #1;
      if (b_in_valid && b_in_ready) void'(pix_b.pop_front());
      if (b_out_valid && b_out_ready) begin
        n_tests++;
        if (exp_b.size() == 0) begin
          n_fail++;
          $display("FAIL b_extra: unexpected output %h", b_out_data);
        end else begin
          e = exp_b.pop_front();
          if (b_out_data !== e.data || b_out_last !== e.last) begin
            n_fail++;
            $display("FAIL b_data: got %h last %b expected %h last %b",
                     b_out_data, b_out_last, e.data, e.last);
          end
        end
      end
      cyc++;
    end
    n_tests++;
    if (cyc >= 300) begin
      n_fail++;
      $display("FAIL b_timeout: %0d pixels and %0d results left", pix_b.size(), exp_b.size());
      pix_b.delete();
      exp_b.delete();
    end
    @(negedge clk);
    b_in_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    a_in_valid = 1'b0; a_in_data = 8'h00; a_out_ready = 1'b1;
    b_in_valid = 1'b0; b_in_data = 16'h0000; b_out_ready = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    n_tests++;
    if (a_out_valid !== 1'b0 || a_out_last !== 1'b0 || a_out_data !== 8'h80 || a_in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_a: valid %b last %b data %h ready %b expected 0 0 80 1",
               a_out_valid, a_out_last, a_out_data, a_in_ready);
    end
    n_tests++;
    if (b_out_valid !== 1'b0 || b_out_data !== 16'h8080 || b_in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_b: valid %b data %h ready %b expected 0 8080 1", b_out_valid, b_out_data, b_in_ready);
    end
    rst = 1'b0;
    @(negedge clk);
    #1;
    n_tests++;
    if (a_in_ready !== 1'b1 || b_in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL ready_after_reset: got %b %b expected 1 1", a_in_ready, b_in_ready);
    end
  endtask

  task automatic test_basic();
    push_frame_a(0);
    run_a(1000, 0, 1'b1);
  endtask

  task automatic test_signed();
    push_frame_a(1);
    run_a(1000, 0, 1'b1);
    push_frame_a(2);
    run_a(1000, 0, 1'b1);
  endtask

  task automatic test_multichannel();
    push_frame_b(0);
    push_frame_b(1);
    run_b();
  endtask

  task automatic test_backpressure();
    push_frame_a(0);
    run_a(6, 5, 1'b0);
  endtask

  task automatic test_back_to_back();
    push_frame_a(3);
    push_frame_a(0);
    run_a(1000, 0, 1'b1);
  endtask

  task automatic test_mid_reset();
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      a_out_ready = 1'b0;
      a_in_valid  = 1'b1;
      a_in_data   = 8'd100;
      #1;
      n_tests++;
      if (a_in_ready !== 1'b1) begin
        n_fail++;
        $display("FAIL frame_a_ready: pixel %0d in_ready got %b expected 1", k, a_in_ready);
      end
    end
    @(negedge clk);
    rst        = 1'b1;
    a_in_valid = 1'b1;
    a_in_data  = 8'd99;
    #1;
    n_tests++;
    if (a_out_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL frame_a_pending: out_valid got %b expected 1", a_out_valid);
    end
    @(negedge clk);
    #1;
    n_tests++;
    if (a_out_valid !== 1'b0 || a_in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL in_reset: out_valid %b in_ready %b expected 0 1", a_out_valid, a_in_ready);
    end
    rst         = 1'b0;
    a_in_valid  = 1'b0;
    a_out_ready = 1'b1;
    push_frame_a(2);
    run_a(1000, 0, 1'b1);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_signed();
    test_multichannel();
    test_backpressure();
    test_back_to_back();
    test_mid_reset();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
